// File: rtl/kanji_fetch.sv
// ----------------------------------------------------------------------------
// kanji_fetch
//
// Downstream stage of the Kanji ROM I/O port block. Turns the port block's
// ram_ce/mem_addr pair into a single SDRAM byte read with a req/ack handshake.
// The fetched byte goes back to the CPU data mux, and Z80 WAIT is held until
// it is valid. A missing ack is forced to complete after TIMEOUT_CYC cycles
// with FAIL_BYTE and raises a sticky timeout flag.
//
// Optional feature macro: KANJI_PREFETCH_EN
//   When defined, the next glyph byte is prefetched after every completed
//   read, following the 32-byte auto-increment of the port (5-bit wrap).
//   A later read of that address is served from the prefetch register with
//   no SDRAM access. inval drops the prefetched byte.
//   When undefined, every read goes to SDRAM and inval is ignored.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   ram_ce     in   Kanji data-port read strobe, high for the whole CPU read
//   mem_addr   in   SDRAM byte address, stable while ram_ce is high
//   inval      in   pulse: Kanji address register written
//   sdram_rd   out  one-cycle read request pulse
//   sdram_addr out  read address, held from sdram_rd until ack
//   sdram_ack  in   one-cycle pulse, sdram_dout valid in the same cycle
//   sdram_dout in   SDRAM read data
//   dout       out  byte to the CPU data mux
//   dout_oe    out  ram_ce & data_valid
//   cpu_wait   out  ram_ce & ~data_valid
//   timeout    out  sticky, set on any CPU-read timeout, cleared by reset
// ----------------------------------------------------------------------------
module kanji_fetch #(
    parameter int         ADDR_W      = 27,
    parameter int         TIMEOUT_CYC = 255,
    parameter logic [7:0] FAIL_BYTE   = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ram_ce,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              inval,
    output logic              sdram_rd,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic              sdram_ack,
    input  logic [7:0]        sdram_dout,
    output logic [7:0]        dout,
    output logic              dout_oe,
    output logic              cpu_wait,
    output logic              timeout
);

    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        HOLD,
        DRAIN
`ifdef KANJI_PREFETCH_EN
        , PREF
`endif
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        ram_ce_q;
    logic        ce_rise;
    logic        data_valid;
    logic        pending;
    logic        serve_pending;
    logic        idle_hit;
    logic        rd_next;
    logic        tc;
    logic [7:0]  cnt;

    assign ce_rise       = ram_ce & ~ram_ce_q;
    assign tc            = (cnt == TERM_CNT);
    // A rising edge seen while the previous read is still draining (or
    // prefetching) is served on exit, but only if the CPU is still waiting.
    assign serve_pending = (pending | ce_rise) & ram_ce;

`ifdef KANJI_PREFETCH_EN
    logic [ADDR_W-1:0] pf_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        pf_data;
    logic              pf_valid;
    logic              pf_drop;
    logic              pref_hit;

    assign next_addr = {sdram_addr[ADDR_W-1:5], sdram_addr[4:0] + 5'd1};
    assign idle_hit  = pf_valid & ~inval & (mem_addr == pf_addr);
    // A read that arrived during PREF can be served straight from the ack.
    assign pref_hit  = sdram_ack & ~pf_drop & ~inval & (mem_addr == sdram_addr);
`else
    logic unused_inval;

    assign unused_inval = inval;
    assign idle_hit     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ce_rise) begin
                    state_next = idle_hit ? HOLD : REQ;
                end
            end
            REQ: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // ack beats the terminal count; a CPU cycle that ended (or
                // restarted) before the ack abandons this byte.
                if (sdram_ack || tc) begin
                    state_next = HOLD;
                end else if (!ram_ce || ce_rise) begin
                    state_next = DRAIN;
                end
            end
            HOLD: begin
                if (!ram_ce) begin
`ifdef KANJI_PREFETCH_EN
                    state_next = PREF;
`else
                    state_next = IDLE;
`endif
                end
            end
            DRAIN: begin
                if (sdram_ack || tc) begin
                    state_next = serve_pending ? REQ : IDLE;
                end
            end
`ifdef KANJI_PREFETCH_EN
            PREF: begin
                if (sdram_ack || tc) begin
                    if (serve_pending) begin
                        state_next = pref_hit ? HOLD : REQ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        dout_oe  = ram_ce & data_valid;
        cpu_wait = ram_ce & ~data_valid;
        rd_next  = (state_next == REQ);
`ifdef KANJI_PREFETCH_EN
        rd_next  = rd_next | ((state_next == PREF) && (state != PREF));
`endif
    end

    // Datapath: address/data capture, timeout counter and the sticky flag.
    // sdram_rd is registered from the next state so it is high for exactly
    // the first cycle of REQ (or PREF).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_ce_q   <= 1'b0;
            sdram_rd   <= 1'b0;
            sdram_addr <= '0;
            dout       <= 8'h00;
            data_valid <= 1'b0;
            timeout    <= 1'b0;
            cnt        <= 8'd0;
            pending    <= 1'b0;
`ifdef KANJI_PREFETCH_EN
            pf_addr    <= '0;
            pf_data    <= 8'h00;
            pf_valid   <= 1'b0;
            pf_drop    <= 1'b0;
`endif
        end else begin
            ram_ce_q <= ram_ce;
            sdram_rd <= rd_next;
            case (state)
                IDLE: begin
                    if (ce_rise) begin
                        if (idle_hit) begin
`ifdef KANJI_PREFETCH_EN
                            dout       <= pf_data;
`endif
                            data_valid <= 1'b1;
                        end else begin
                            sdram_addr <= mem_addr;
`ifdef KANJI_PREFETCH_EN
                            pf_valid   <= 1'b0;
`endif
                        end
                    end
                end
                REQ: begin
                    cnt     <= 8'd0;
                    pending <= 1'b0;
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        dout       <= sdram_dout;
                        data_valid <= 1'b1;
                    end else if (tc) begin
                        dout       <= FAIL_BYTE;
                        data_valid <= 1'b1;
                        timeout    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (ce_rise) begin
                            pending <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!ram_ce) begin
                        data_valid <= 1'b0;
`ifdef KANJI_PREFETCH_EN
                        sdram_addr <= next_addr;
                        pf_addr    <= next_addr;
                        pf_valid   <= 1'b0;
                        pf_drop    <= inval;
                        cnt        <= 8'd0;
`endif
                    end
                end
                DRAIN: begin
                    if (sdram_ack || tc) begin
                        pending <= 1'b0;
                        if (!sdram_ack) begin
                            timeout <= 1'b1;
                        end
                        if (serve_pending) begin
                            sdram_addr <= mem_addr;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (ce_rise) begin
                            pending <= 1'b1;
                        end
                    end
                end
`ifdef KANJI_PREFETCH_EN
                PREF: begin
                    // A prefetch timeout only leaves pf_valid low; it never
                    // touches the CPU-visible timeout flag.
                    if (sdram_ack || tc) begin
                        pending <= 1'b0;
                        if (sdram_ack && !pf_drop && !inval) begin
                            pf_data  <= sdram_dout;
                            pf_valid <= 1'b1;
                        end
                        if (serve_pending) begin
                            if (pref_hit) begin
                                dout       <= sdram_dout;
                                data_valid <= 1'b1;
                            end else begin
                                sdram_addr <= mem_addr;
                                pf_valid   <= 1'b0;
                            end
                        end
                    end else begin
                        // The request cycle itself is not counted, so the
                        // ack window matches the REQ/WAIT_ACK path.
                        if (!sdram_rd) begin
                            cnt <= cnt + 8'd1;
                        end
                        if (ce_rise) begin
                            pending <= 1'b1;
                        end
                        if (inval) begin
                            pf_drop <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
`ifdef KANJI_PREFETCH_EN
            if (inval) begin
                pf_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_kanji_fetch.sv
// ----------------------------------------------------------------------------
// tb_kanji_fetch
//
// Self-checking bench for kanji_fetch. A behavioural SDRAM responder answers
// every sdram_rd after a programmable delay with bytes from a fixed backing
// memory function. The expected byte, WAIT length and request count of each
// CPU read come from a read-level model: the byte is the memory content (or
// FAIL_BYTE if no ack arrives within the window), and with
// KANJI_PREFETCH_EN the model tracks which single address was prefetched.
// ----------------------------------------------------------------------------
module tb_kanji_fetch;

    localparam int         ADDR_W    = 27;
    localparam logic [7:0] FAIL_BYTE = 8'hFF;
    // ack delays from 1 to this many cycles after sdram_rd are accepted
    localparam int         ACK_WIN   = 256;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              ram_ce     = 1'b0;
    logic [ADDR_W-1:0] mem_addr   = '0;
    logic              inval      = 1'b0;
    logic              sdram_ack  = 1'b0;
    logic [7:0]        sdram_dout = 8'h00;
    logic              sdram_rd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [7:0]        dout;
    logic              dout_oe;
    logic              cpu_wait;
    logic              timeout;

    int checks   = 0;
    int failures = 0;

    int                resp_delay   = 0;
    int                ack_cd       = 0;
    int                rd_count     = 0;
    logic [ADDR_W-1:0] last_rd_addr = '0;

    bit                pf_valid_m = 1'b0;
    logic [ADDR_W-1:0] pf_addr_m  = '0;

    kanji_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ram_ce     (ram_ce),
        .mem_addr   (mem_addr),
        .inval      (inval),
        .sdram_rd   (sdram_rd),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dout (sdram_dout),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .cpu_wait   (cpu_wait),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Backing memory; byte 0x40 is seeded with 8'hA5.
    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        if (a == 27'h40) begin
            return 8'hA5;
        end
        t = a ^ (a >> 8) ^ (a >> 16);
        return t[7:0] ^ 8'h3C;
    endfunction

    // Glyph auto-increment: low 5 bits wrap, upper bits unchanged.
    function automatic logic [ADDR_W-1:0] glyph_next(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] n;
        n      = a;
        n[4:0] = a[4:0] + 5'd1;
        return n;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // SDRAM responder: ack resp_delay cycles after each request (0 = never).
    always @(negedge clk) begin
        sdram_ack = 1'b0;
        if (ack_cd > 0) begin
            ack_cd--;
            if (ack_cd == 0) begin
                sdram_ack  = 1'b1;
                sdram_dout = mem_byte(last_rd_addr);
            end
        end
        if (sdram_rd === 1'b1) begin
            check_output("one_outstanding", ack_cd, 0);
            rd_count++;
            last_rd_addr = sdram_addr;
            ack_cd       = resp_delay;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_sdram_rd"}, sdram_rd, 0);
        check_output({tag, "_sdram_addr"}, sdram_addr, 0);
        check_output({tag, "_dout"}, dout, 0);
        check_output({tag, "_dout_oe"}, dout_oe, 0);
        check_output({tag, "_cpu_wait"}, cpu_wait, 0);
        check_output({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic pulse_inval();
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
`ifdef KANJI_PREFETCH_EN
        pf_valid_m = 1'b0;
`endif
    endtask

    // One complete CPU read of address a, with the responder using delay d.
    task automatic apply_stimulus(input logic [ADDR_W-1:0] a, input int d,
                                  input int hold_cyc, input string tag);
        bit         hit;
        bit         good;
        bit         wait_ok;
        bit         stable;
        int         exp_lat;
        int         lat;
        int         rd0;
        logic [7:0] exp_data;

        hit      = pf_valid_m && (a == pf_addr_m);
        good     = (d >= 1) && (d <= ACK_WIN);
        exp_data = (hit || good) ? mem_byte(a) : FAIL_BYTE;
        // ce_rise in cycle N, request in N+1, ack in N+1+d, byte out N+2+d;
        // a missing ack completes at the end of the window instead.
        exp_lat  = hit ? 1 : (good ? d + 2 : ACK_WIN + 2);
        resp_delay = d;
        rd0 = rd_count;

        @(negedge clk);
        mem_addr = a;
        ram_ce   = 1'b1;
        lat      = 0;
        wait_ok  = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (dout_oe !== 1'b1 && cpu_wait !== 1'b1) begin
                wait_ok = 1'b0;
            end
        end while (dout_oe !== 1'b1 && lat < 400);

        check_output({tag, "_latency"}, lat, exp_lat);
        check_output({tag, "_dout"}, dout, exp_data);
        check_output({tag, "_wait_released"}, cpu_wait, 0);
        check_output({tag, "_wait_held"}, wait_ok, 1);
        check_output({tag, "_rd_pulses"}, rd_count - rd0, hit ? 0 : 1);
        if (!hit) begin
            check_output({tag, "_rd_addr"}, last_rd_addr, a);
        end

        stable = 1'b1;
        repeat (hold_cyc) begin
            @(negedge clk);
            if (dout_oe !== 1'b1 || dout !== exp_data || cpu_wait !== 1'b0) begin
                stable = 1'b0;
            end
        end
        check_output({tag, "_hold_stable"}, stable, 1);
        ram_ce = 1'b0;
        @(negedge clk);
        check_output({tag, "_released"}, {dout_oe, cpu_wait}, 2'b00);

`ifdef KANJI_PREFETCH_EN
        pf_addr_m  = glyph_next(a);
        pf_valid_m = good;
`endif
        // leave room for the background prefetch to finish
        repeat (good ? d + 8 : ACK_WIN + 14) @(negedge clk);
    endtask

    initial begin
        int                rd0;
        int                lat;
        int                first_oe;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] prev;
        int                d;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: basic read, ack 3 cycles after the request
        apply_stimulus(27'h40, 3, 3, "t1");
        check_output("t1_no_timeout", timeout, 0);

        // ack exactly at the terminal count wins, flag stays clear
        apply_stimulus(27'h300, ACK_WIN, 1, "ack_at_tc");
        check_output("ack_at_tc_flag", timeout, 0);

        // T2: no ack at all
        apply_stimulus(27'h1234, 0, 2, "t2");
        check_output("t2_flag", timeout, 1);
        apply_stimulus(27'h2200, 4, 1, "t2_good");
        check_output("t2_flag_sticky", timeout, 1);

        // T3: CPU cycle abandoned after the request, new read during DRAIN
        pulse_inval();
        a = 27'h0123_456;
        b = 27'h0654_321;
        resp_delay = 5;
        rd0 = rd_count;
        @(negedge clk);
        mem_addr = a;
        ram_ce   = 1'b1;
        lat      = 0;
        first_oe = 0;
        while (first_oe == 0 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (dout_oe === 1'b1) begin
                first_oe = lat;
            end
            if (lat == 2) begin
                ram_ce = 1'b0;
            end
            if (lat == 4) begin
                mem_addr = b;
                ram_ce   = 1'b1;
            end
        end
        // first ack at N+6 ends DRAIN, re-request at N+7, ack N+12, valid N+13
        check_output("t3_latency", first_oe, 13);
        check_output("t3_rd_pulses", rd_count - rd0, 2);
        check_output("t3_rd_addr", last_rd_addr, b);
        check_output("t3_dout", dout, mem_byte(b));
        @(negedge clk);
        ram_ce = 1'b0;
`ifdef KANJI_PREFETCH_EN
        pf_addr_m  = glyph_next(b);
        pf_valid_m = 1'b1;
`endif
        repeat (14) @(negedge clk);

`ifdef KANJI_PREFETCH_EN
        // T4: prefetch wraps inside the 32-byte glyph, then hits
        pulse_inval();
        rd0 = rd_count;
        apply_stimulus(27'h5F, 3, 1, "t4_first");
        check_output("t4_pf_addr", last_rd_addr, 27'h40);
        check_output("t4_pf_rd", rd_count - rd0, 2);
        apply_stimulus(27'h40, 3, 1, "t4_hit");
        // T5: inval drops the prefetched byte
        pulse_inval();
        apply_stimulus(27'h41, 3, 1, "t5_miss");
`endif

        // randomized reads, half of them following the glyph auto-increment
        prev = 27'h0000_100;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = glyph_next(prev);
            end else begin
                a = ADDR_W'($urandom);
            end
            d = $urandom_range(1, 8);
            apply_stimulus(a, d, $urandom_range(0, 3), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 4) == 0) begin
                pulse_inval();
            end
            prev = a;
        end

        // T6: reset in WAIT_ACK, ack arrives afterwards
        resp_delay = 10;
        rd0 = rd_count;
        @(negedge clk);
        mem_addr = 27'h0AB_CDE;
        ram_ce   = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        ram_ce  = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_in_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (9) @(negedge clk);
        check_reset_outputs("t6_after_ack");
        check_output("t6_rd_pulses", rd_count - rd0, 1);
        pf_valid_m = 1'b0;
        apply_stimulus(27'h0AB_CDE, 2, 1, "t6_recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
